// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: HI/LO registers, multi-cycle mult/div
// with a fixed busy window, and mfhi/mflo/mthi/mtlo service.
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] E_FW_Rdata1,
   input  logic [31:0] E_FW_Rdata2,
   input  logic [3:0]  E_MDUop,
   output logic        E_MDU_start,
   output logic        E_MDU_busy,
   output logic [31:0] E_MDU_out,
   output logic [31:0] E_HI,
   output logic [31:0] E_LO
);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } mdu_op_e;

   mdu_op_e     op;
   logic [31:0] hi_q, lo_q, hi_tmp, lo_tmp;
   logic [31:0] cnt;
   logic        busy_q, wr_en;
   logic [31:0] hi_res, lo_res;
   logic        is_mul, is_div;

   logic [63:0] prod_s, prod_u;
   logic [31:0] mag_a, mag_b, div_b, uq, ur;
   logic        neg_a, neg_b;

   assign op     = mdu_op_e'(E_MDUop);
   assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div = (op == OP_DIV)  || (op == OP_DIVU);

   // Signed divide works on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
   always_comb begin
      prod_s = $signed({{32{E_FW_Rdata1[31]}}, E_FW_Rdata1}) *
               $signed({{32{E_FW_Rdata2[31]}}, E_FW_Rdata2});
      prod_u = {32'd0, E_FW_Rdata1} * {32'd0, E_FW_Rdata2};
      neg_a  = (op == OP_DIV) && E_FW_Rdata1[31];
      neg_b  = (op == OP_DIV) && E_FW_Rdata2[31];
      mag_a  = neg_a ? (~E_FW_Rdata1 + 32'd1) : E_FW_Rdata1;
      mag_b  = neg_b ? (~E_FW_Rdata2 + 32'd1) : E_FW_Rdata2;
      div_b  = (mag_b == '0) ? 32'd1 : mag_b;
      uq     = mag_a / div_b;
      ur     = mag_a % div_b;
      hi_res = '0;
      lo_res = '0;
      case (op)
         OP_MULT:  {hi_res, lo_res} = prod_s;
         OP_MULTU: {hi_res, lo_res} = prod_u;
         OP_DIV, OP_DIVU: begin
            lo_res = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
            hi_res = neg_a ? (~ur + 32'd1) : ur;
         end
         default: ;
      endcase
   end

   assign E_MDU_start = (is_mul || is_div) && !busy_q;
   assign E_MDU_busy  = busy_q;
   assign E_HI        = hi_q;
   assign E_LO        = lo_q;

   always_comb begin
      E_MDU_out = '0;
      if (op == OP_MFHI) E_MDU_out = hi_q;
      else if (op == OP_MFLO) E_MDU_out = lo_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         hi_tmp <= '0;
         lo_tmp <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
         wr_en  <= 1'b0;
      end else if (busy_q) begin
         if (cnt == 32'd1) begin
            if (wr_en) begin
               hi_q <= hi_tmp;
               lo_q <= lo_tmp;
            end
            busy_q <= 1'b0;
            cnt    <= '0;
         end else begin
            cnt <= cnt - 32'd1;
         end
      end else if (E_MDU_start) begin
         hi_tmp <= hi_res;
         lo_tmp <= lo_res;
         cnt    <= is_mul ? MULT_CYCLES : DIV_CYCLES;
         busy_q <= 1'b1;
         // Divide by zero still occupies the window but leaves HI/LO untouched.
         wr_en  <= !(is_div && (E_FW_Rdata2 == '0));
      end else if (op == OP_MTHI) begin
         hi_q <= E_FW_Rdata1;
      end else if (op == OP_MTLO) begin
         lo_q <= E_FW_Rdata1;
      end
   end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu with hand-computed HI/LO results.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] E_FW_Rdata1, E_FW_Rdata2;
   logic [3:0]  E_MDUop;
   logic        E_MDU_start, E_MDU_busy;
   logic [31:0] E_MDU_out, E_HI, E_LO;

   int total = 0;
   int bad   = 0;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset),
      .E_FW_Rdata1(E_FW_Rdata1), .E_FW_Rdata2(E_FW_Rdata2),
      .E_MDUop(E_MDUop), .E_MDU_start(E_MDU_start), .E_MDU_busy(E_MDU_busy),
      .E_MDU_out(E_MDU_out), .E_HI(E_HI), .E_LO(E_LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      E_MDUop     = op;
      E_FW_Rdata1 = a;
      E_FW_Rdata2 = b;
      #1;
   endtask

   // Start a mult/div, then verify busy holds for exactly n cycles.
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int n);
      drive(op, a, b);
      chk({tag, "_start"}, {31'd0, E_MDU_start}, 32'd1);
      tick();
      drive(4'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_busy"}, {31'd0, E_MDU_busy}, 32'd1);
         tick();
      end
      chk({tag, "_idle"}, {31'd0, E_MDU_busy}, 32'd0);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (E_MDU_busy && k < 40) begin
         tick();
         k++;
      end
      chk({tag, "_timeout"}, {31'd0, E_MDU_busy}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      drive(4'd0, '0, '0);
      tick();
      chk("rst_hi", E_HI, 32'd0);
      chk("rst_lo", E_LO, 32'd0);
      chk("rst_busy", {31'd0, E_MDU_busy}, 32'd0);
      chk("rst_out", E_MDU_out, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // 1: mult / multu
      run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'h0000_0003, 5);
      chk("mult_hi", E_HI, 32'hFFFF_FFFF);
      chk("mult_lo", E_LO, 32'hFFFF_FFFA);
      drive(4'd5, '0, '0);
      chk("mfhi_out", E_MDU_out, 32'hFFFF_FFFF);
      drive(4'd12, '0, '0);
      chk("op12_out", E_MDU_out, 32'd0);
      run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'h0000_0003, 5);
      chk("multu_hi", E_HI, 32'h0000_0002);
      chk("multu_lo", E_LO, 32'hFFFF_FFFA);

      // 2: div / divu
      run_op("div", 4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 10);
      chk("div_lo", E_LO, 32'hFFFF_FFFD);
      chk("div_hi", E_HI, 32'hFFFF_FFFF);
      run_op("divu", 4'd4, 32'd7, 32'd2, 10);
      chk("divu_lo", E_LO, 32'd3);
      chk("divu_hi", E_HI, 32'd1);

      // 3: divide by zero and INT_MIN / -1
      drive(4'd7, 32'h1234, '0);
      tick();
      drive(4'd8, 32'h5678, '0);
      tick();
      chk("mthi", E_HI, 32'h1234);
      chk("mtlo", E_LO, 32'h5678);
      run_op("div0", 4'd3, 32'd5, 32'd0, 10);
      chk("div0_hi", E_HI, 32'h1234);
      chk("div0_lo", E_LO, 32'h5678);
      run_op("divmin", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      chk("divmin_lo", E_LO, 32'h8000_0000);
      chk("divmin_hi", E_HI, 32'd0);

      // 4: hazard tolerance while busy
      drive(4'd7, 32'h77, '0);
      tick();
      drive(4'd1, 32'd3, 32'd4);
      chk("hz_start", {31'd0, E_MDU_start}, 32'd1);
      tick();
      drive(4'd0, '0, '0);
      tick();
      drive(4'd8, 32'hAAAA, '0);
      chk("hz_mtlo_start", {31'd0, E_MDU_start}, 32'd0);
      tick();
      chk("hz_lo_kept", E_LO, 32'h8000_0000);
      drive(4'd5, '0, '0);
      chk("hz_mfhi_old", E_MDU_out, 32'h77);
      drive(4'd1, 32'd9, 32'd9);
      chk("hz_mult_start", {31'd0, E_MDU_start}, 32'd0);
      tick();
      drive(4'd0, '0, '0);
      wait_idle("hz");
      chk("hz_lo", E_LO, 32'd12);
      chk("hz_hi", E_HI, 32'd0);

      // 5: asynchronous reset mid-divide
      drive(4'd3, 32'd100, 32'd7);
      tick();
      drive(4'd0, '0, '0);
      tick();
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("ar_busy", {31'd0, E_MDU_busy}, 32'd0);
      chk("ar_hi", E_HI, 32'd0);
      chk("ar_lo", E_LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      drive(4'd6, '0, '0);
      chk("ar_late_lo", E_LO, 32'd0);
      chk("ar_late_hi", E_HI, 32'd0);
      chk("ar_mflo", E_MDU_out, 32'd0);

      // 6: back-to-back with a held second mult
      drive(4'd1, 32'd2, 32'd3);
      chk("b2b_start1", {31'd0, E_MDU_start}, 32'd1);
      tick();
      drive(4'd1, 32'd5, 32'd5);
      for (int i = 0; i < 4; i++) begin
         chk("b2b_blocked", {31'd0, E_MDU_start}, 32'd0);
         tick();
      end
      chk("b2b_last_busy", {31'd0, E_MDU_busy}, 32'd1);
      tick();
      chk("b2b_fall", {31'd0, E_MDU_busy}, 32'd0);
      chk("b2b_start2", {31'd0, E_MDU_start}, 32'd1);
      chk("b2b_lo1", E_LO, 32'd6);
      tick();
      drive(4'd6, '0, '0);
      chk("b2b_busy2", {31'd0, E_MDU_busy}, 32'd1);
      chk("b2b_mflo6", E_MDU_out, 32'd6);
      wait_idle("b2b");
      chk("b2b_mflo25", E_MDU_out, 32'd25);
      chk("b2b_hi", E_HI, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
Execute-stage multiply/divide unit. Sits directly downstream of the E-stage forwarding mux and consumes its forwarded operands E_FW_Rdata1 (rs) and E_FW_Rdata2 (rt).
- Holds the architectural HI/LO registers.
- Runs multi-cycle mult/multu/div/divu.
- Serves mfhi/mflo/mthi/mtlo.
- Exports busy/start so the D-stage hazard unit can stall MDU-class instructions.

Parameters:
MULT_CYCLES, 5, cycles busy is held after a mult/multu start (>=1)
DIV_CYCLES, 10, cycles busy is held after a div/divu start (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
E_FW_Rdata1  input  32  forwarded rs operand
E_FW_Rdata2  input  32  forwarded rt operand
E_MDUop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none
E_MDU_start  output  1  combinational: E_MDUop in {1..4} and E_MDU_busy==0
E_MDU_busy  output  1  registered: operation in flight
E_MDU_out  output  32  combinational: HI for mfhi, LO for mflo, else 0
E_HI  output  32  current HI register (debug/visibility)
E_LO  output  32  current LO register

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is asynchronous and active-high.
  - On reset: HI=0, LO=0, E_MDU_busy=0, internal counter=0, pending result discarded.
  - Reset mid-operation aborts with no HI/LO write.
- Start:
  - At the rising edge where E_MDU_start==1, latch the computed result into internal HI_tmp/LO_tmp from the operands present that cycle.
  - Load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4) and set busy=1.
  - Operands may change after the start edge without effect.
- Count:
  - While busy, counter decrements each edge.
  - On the edge where counter==1: HI<=HI_tmp, LO<=LO_tmp, busy<=0, counter<=0.
  - Busy is therefore high for exactly N cycles after the start edge.
  - New HI/LO become visible to mfhi/mflo in the cycle busy falls.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=upper, LO=lower.
  - multu: unsigned 32x32 -> 64.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor zero (div or divu): the operation still runs the full DIV_CYCLES busy window, and HI/LO are left unchanged at completion.
- mthi/mtlo:
  - When busy==0, HI (or LO) <= E_FW_Rdata1 at the next edge, single cycle, no busy.
- mfhi/mflo:
  - E_MDU_out is purely combinational from the current HI/LO registers, zero latency.
- Any MDU op while busy==1 (start-class, mthi/mtlo, mfhi/mflo):
  - Ignored: no state change, and E_MDU_start stays 0.
  - The hazard unit guarantees these never reach E under correct operation. The block must still tolerate them without corruption; E_MDU_out still reflects the old HI/LO.
- Ops 0 and 9-15: no state change, E_MDU_out=0.
- Back-to-back: a start-class op in the same cycle busy falls is blocked, because busy is still 1 that cycle. It starts on the following cycle.

Test Plan:
1. mult 0xFFFFFFFE x 0x00000003, one cycle -> start=1 that cycle; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu -> HI=0x00000002, LO=0xFFFFFFFA.
2. div 0xFFFFFFF9 (-7) / 0x00000002 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu 7 / 2 -> LO=3, HI=1.
3. Divide by zero: mthi 0x1234, mtlo 0x5678, then div 5 / 0 -> busy 10 cycles; afterwards HI=0x1234, LO=0x5678. Separately, div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. Hazard tolerance: start mult 3x4; 2 cycles later apply mtlo 0xAAAA and mfhi while busy -> start=0, no corruption. Final LO=12, HI=0, and E_MDU_out during busy shows the old HI.
5. Reset mid-op: start div; assert reset asynchronously (between edges) 4 cycles in -> busy, HI and LO go to 0 immediately. After release, no late write occurs and mflo returns 0.
6. Back-to-back and forwarding latency: mult 2x3 followed by a held mult 5x5 -> second start occurs the cycle after busy falls, giving LO=6 then LO=25. mflo in the cycle busy falls returns 6 combinationally.
